melody_sequencer: RTL and testbench

Plays a fixed song from an internal ROM by driving a one-hot 8-bit note select, one note at a time, for a programmed number of beats. Sits directly upstream of the piezo tone/FND stage: its `note_sel` output connects to that stage's 8-bit switch input in place of the board switches. All timing is derived from `clk` with no external beat source.

---
 rtl/melody_pkg.sv | 49 ++++
 rtl/melody_rom.sv | 25 ++
 rtl/melody_sequencer.sv | 174 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: FSM states, ROM note codes,
// one-hot note encodings (bit7 = C ... bit0 = high C) and the code decoder.
// No logic of its own; imported by melody_rom and melody_sequencer.
package melody_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // ROM note codes (upper nibble of an entry)
   localparam logic [3:0] CODE_REST = 4'h0;
   localparam logic [3:0] CODE_C    = 4'h1;
   localparam logic [3:0] CODE_D    = 4'h2;
   localparam logic [3:0] CODE_E    = 4'h3;
   localparam logic [3:0] CODE_F    = 4'h4;
   localparam logic [3:0] CODE_G    = 4'h5;
   localparam logic [3:0] CODE_A    = 4'h6;
   localparam logic [3:0] CODE_B    = 4'h7;
   localparam logic [3:0] CODE_HC   = 4'h8;
   localparam logic [3:0] CODE_END  = 4'hF;

   // One-hot selects matching the piezo stage's switch decode
   localparam logic [7:0] OH_C  = 8'b1000_0000;
   localparam logic [7:0] OH_D  = 8'b0100_0000;
   localparam logic [7:0] OH_E  = 8'b0010_0000;
   localparam logic [7:0] OH_F  = 8'b0001_0000;
   localparam logic [7:0] OH_G  = 8'b0000_1000;
   localparam logic [7:0] OH_A  = 8'b0000_0100;
   localparam logic [7:0] OH_B  = 8'b0000_0010;
   localparam logic [7:0] OH_HC = 8'b0000_0001;

   // Rests (0, 9-14) and END all decode to silence
   function automatic logic [7:0] code_to_onehot(input logic [3:0] code);
      case (code)
         CODE_C:  return OH_C;
         CODE_D:  return OH_D;
         CODE_E:  return OH_E;
         CODE_F:  return OH_F;
         CODE_G:  return OH_G;
         CODE_A:  return OH_A;
         CODE_B:  return OH_B;
         CODE_HC: return OH_HC;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/melody_rom.sv
// Song ROM: address -> 8-bit entry {code[7:4], dur[3:0]}; swap songs here only.
// Latency: purely combinational, no clock.
// Backpressure: none. Ports: i_addr (ADDR_W) in, o_entry (8) out.
module melody_rom #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic [7:0]        o_entry
);
   import melody_pkg::*;

   always_comb begin
      // Unprogrammed locations read as END so a short song always terminates
      o_entry = {CODE_END, 4'd0};
      case (i_addr)
         ADDR_W'(0): o_entry = {CODE_C,    4'd2};
         ADDR_W'(1): o_entry = {CODE_E,    4'd1};
         ADDR_W'(2): o_entry = {CODE_REST, 4'd1};
         ADDR_W'(3): o_entry = {CODE_HC,   4'd1};
         ADDR_W'(4): o_entry = {CODE_END,  4'd0};
         default:    o_entry = {CODE_END,  4'd0};
      endcase
   end

endmodule

// File: rtl/melody_sequencer.sv
// Plays the song in melody_rom as a one-hot note select, dur beats per entry,
// with GAP_TICKS of silence closing every note. Latency: start sampled at edge N
// -> note after edge N+1; stop at edge N -> silent/idle after edge N. No backpressure.
// Ports: i_clk, i_rst_n (async active-low), i_start (level), i_stop,
//        o_note_sel[7:0], o_busy, o_done (1-cycle pulse), o_note_idx[ADDR_W-1:0].
// Build option: MELODY_LOOP_EN -- restart from entry 0 at END/wrap instead of idling.
module melody_sequencer #(
   parameter int TICKS_PER_BEAT = 100000,
   parameter int GAP_TICKS      = 10000,
   parameter int ADDR_W         = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_stop,
   output logic [7:0]        o_note_sel,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_note_idx
);
   import melody_pkg::*;

   localparam int CNT_W = $clog2(15*TICKS_PER_BEAT+1);

   state_t            r_state,    w_state_nxt;
   logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
   logic [ADDR_W-1:0] r_idx,      w_idx_nxt;
   logic [7:0]        r_note_sel, w_note_nxt;
   logic              r_busy,     w_busy_nxt;
   logic              r_done,     w_done_nxt;
   logic              r_start_q,  w_start_q_nxt;

   logic [ADDR_W-1:0] w_idx_inc;
   logic [7:0]        w_first_entry;
   logic [7:0]        w_next_entry;
   logic              w_first_end;
   logic              w_next_end;

   // Sounding part of a note; dur 0 plays as one beat
   function automatic logic [CNT_W-1:0] play_ticks(input logic [3:0] dur);
      logic [CNT_W-1:0] beats;
      beats = (dur == 4'd0) ? CNT_W'(1) : CNT_W'(dur);
      return beats * CNT_W'(TICKS_PER_BEAT) - CNT_W'(GAP_TICKS);
   endfunction

   assign w_idx_inc = r_idx + ADDR_W'(1);

   // Entry 0 is read on its own port so a loop restart needs no extra cycle
   melody_rom #(.ADDR_W(ADDR_W)) u_rom_first (
      .i_addr  ('0),
      .o_entry (w_first_entry)
   );

   melody_rom #(.ADDR_W(ADDR_W)) u_rom_next (
      .i_addr  (w_idx_inc),
      .o_entry (w_next_entry)
   );

   assign w_first_end = (w_first_entry[7:4] == CODE_END);
   // Running off the top of the ROM ends the song just like END
   assign w_next_end  = (w_next_entry[7:4] == CODE_END) || (&r_idx);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_note_nxt    = r_note_sel;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_start_q_nxt = 1'b0;

      if (i_stop) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
         w_note_nxt  = '0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_cnt_nxt  = '0;
               w_idx_nxt  = '0;
               w_note_nxt = '0;
               w_busy_nxt = 1'b0;
               // Start is captured one cycle before entry 0 is loaded
               if (r_start_q) begin
                  if (w_first_end) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_PLAY;
                     w_busy_nxt  = 1'b1;
                     w_note_nxt  = code_to_onehot(w_first_entry[7:4]);
                     w_cnt_nxt   = play_ticks(w_first_entry[3:0]);
                  end
               end else if (i_start) begin
                  w_start_q_nxt = 1'b1;
               end
            end
            ST_PLAY: begin
               if (r_cnt <= CNT_W'(1)) begin
                  w_state_nxt = ST_GAP;
                  w_note_nxt  = '0;
                  w_cnt_nxt   = CNT_W'(GAP_TICKS);
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (r_cnt > CNT_W'(1)) begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end else if (w_next_end) begin
                  w_done_nxt = 1'b1;
`ifdef MELODY_LOOP_EN
                  if (w_first_end) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                     w_idx_nxt   = '0;
                     w_busy_nxt  = 1'b0;
                  end else begin
                     w_state_nxt = ST_PLAY;
                     w_idx_nxt   = '0;
                     w_note_nxt  = code_to_onehot(w_first_entry[7:4]);
                     w_cnt_nxt   = play_ticks(w_first_entry[3:0]);
                  end
`else
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
                  w_busy_nxt  = 1'b0;
`endif
               end else begin
                  w_state_nxt = ST_PLAY;
                  w_idx_nxt   = w_idx_inc;
                  w_note_nxt  = code_to_onehot(w_next_entry[7:4]);
                  w_cnt_nxt   = play_ticks(w_next_entry[3:0]);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_note_nxt  = '0;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_note_sel <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_start_q  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_note_sel <= w_note_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_start_q  <= w_start_q_nxt;
      end
   end

   assign o_note_sel = r_note_sel;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_note_idx = r_idx;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed, table-driven bench for melody_sequencer with TICKS_PER_BEAT=8,
// GAP_TICKS=2 and the ROM song {C,2},{E,1},{rest,1},{HC,1},END.
module tb_melody_sequencer;

   localparam logic [7:0] N_C  = 8'b1000_0000;
   localparam logic [7:0] N_E  = 8'b0010_0000;
   localparam logic [7:0] N_HC = 8'b0000_0001;
   localparam logic [7:0] N_0  = 8'h00;

   typedef struct {
      logic       start;
      logic       stop;
      logic [7:0] note;
      logic       busy;
      logic       done;
      logic [4:0] idx;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] note_sel;
   logic       busy;
   logic       done;
   logic [4:0] note_idx;

   int checks = 0;
   int failures = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   melody_sequencer #(
      .TICKS_PER_BEAT (8),
      .GAP_TICKS      (2),
      .ADDR_W         (5)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_stop     (stop),
      .o_note_sel (note_sel),
      .o_busy     (busy),
      .o_done     (done),
      .o_note_idx (note_idx)
   );

   task automatic chk(input string name, input int vi, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, vi, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic sp, input logic [7:0] n, input logic b,
                      input logic d, input logic [4:0] ix, input int cnt);
      for (int k = 0; k < cnt; k++)
         vq.push_back('{start: st, stop: sp, note: n, busy: b, done: d, idx: ix});
   endtask

   // Called at a negedge: drive, let one posedge happen, check at next negedge
   task automatic run_vectors(input string tag);
      foreach (vq[i]) begin
         start = vq[i].start;
         stop  = vq[i].stop;
         @(posedge clk);
         @(negedge clk);
         chk({tag, ".note"}, i, 32'(note_sel), 32'(vq[i].note));
         chk({tag, ".busy"}, i, 32'(busy),     32'(vq[i].busy));
         chk({tag, ".done"}, i, 32'(done),     32'(vq[i].done));
         chk({tag, ".idx"},  i, 32'(note_idx), 32'(vq[i].idx));
      end
      start = 1'b0;
      stop  = 1'b0;
      vq.delete();
   endtask

   // Whole song; repulse raises start again while busy (must be ignored)
   task automatic add_song(input logic repulse);
      add(1, 0, N_0, 0, 0, 0, 1);
      if (repulse) begin
         add(0, 0, N_C, 1, 0, 0, 4);
         add(1, 0, N_C, 1, 0, 0, 2);
         add(0, 0, N_C, 1, 0, 0, 8);
      end else begin
         add(0, 0, N_C, 1, 0, 0, 14);
      end
      add(0, 0, N_0,  1, 0, 0, 2);
      add(0, 0, N_E,  1, 0, 1, 6);
      add(repulse, 0, N_0, 1, 0, 1, 2);
      add(0, 0, N_0,  1, 0, 2, 8);
      add(0, 0, N_HC, 1, 0, 3, 6);
      add(0, 0, N_0,  1, 0, 3, 2);
`ifdef MELODY_LOOP_EN
      add(0, 0, N_C, 1, 1, 0, 1);
      add(0, 0, N_C, 1, 0, 0, 3);
      add(0, 1, N_0, 0, 0, 0, 1);
      add(0, 0, N_0, 0, 0, 0, 2);
`else
      add(0, 0, N_0, 0, 1, 0, 1);
      add(0, 0, N_0, 0, 0, 0, 2);
`endif
   endtask

   initial begin
      // Reset state, while held and after release
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.note", 0, 32'(note_sel), 32'h0);
      chk("rst.busy", 0, 32'(busy),     32'h0);
      chk("rst.done", 0, 32'(done),     32'h0);
      chk("rst.idx",  0, 32'(note_idx), 32'h0);
      rst_n = 1'b1;
      add(0, 0, N_0, 0, 0, 0, 2);
      run_vectors("idle");

      // Full song
      add_song(1'b0);
      run_vectors("song");

      // Stop during the 5th cycle of the first note, then replay from entry 0
      add(1, 0, N_0, 0, 0, 0, 1);
      add(0, 0, N_C, 1, 0, 0, 4);
      add(0, 1, N_0, 0, 0, 0, 1);
      add(0, 0, N_0, 0, 0, 0, 3);
      add(1, 0, N_0, 0, 0, 0, 1);
      add(0, 0, N_C, 1, 0, 0, 14);
      add(0, 0, N_0, 1, 0, 0, 2);
      add(0, 0, N_E, 1, 0, 1, 1);
      add(0, 1, N_0, 0, 0, 0, 1);
      add(0, 0, N_0, 0, 0, 0, 2);
      run_vectors("stop");

      // start and stop together in IDLE: nothing happens
      add(1, 1, N_0, 0, 0, 0, 1);
      add(0, 0, N_0, 0, 0, 0, 3);
      run_vectors("both");

      // start re-pulsed while busy: timing unchanged
      add_song(1'b1);
      run_vectors("repulse");

      // Async reset in the first GAP cycle after E
      add(1, 0, N_0, 0, 0, 0, 1);
      add(0, 0, N_C, 1, 0, 0, 14);
      add(0, 0, N_0, 1, 0, 0, 2);
      add(0, 0, N_E, 1, 0, 1, 6);
      add(0, 0, N_0, 1, 0, 1, 1);
      run_vectors("pregap");
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gap.note", 0, 32'(note_sel), 32'h0);
      chk("arst_gap.busy", 0, 32'(busy),     32'h0);
      chk("arst_gap.idx",  0, 32'(note_idx), 32'h0);
      chk("arst_gap.done", 0, 32'(done),     32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      add(0, 0, N_0, 0, 0, 0, 2);
      add(1, 0, N_0, 0, 0, 0, 1);
      add(0, 0, N_C, 1, 0, 0, 3);
      run_vectors("preplay");

      // Async reset while a note sounds: silenced before the next edge
      #2 rst_n = 1'b0;
      #1;
      chk("arst_play.note", 0, 32'(note_sel), 32'h0);
      chk("arst_play.busy", 0, 32'(busy),     32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      add(0, 0, N_0, 0, 0, 0, 2);
      run_vectors("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
